// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions.
// Holds the default Prescale/edge_cnt width, the legality check applied to the
// per-bit sample count, and the majority threshold helper used by the voter.
package uart_pkg;

  localparam int PRESC_W_DEF = 6;

  // Sample count must be odd so a vote can never tie; 7 caps the accumulator at 3 bits.
  function automatic bit num_samples_ok(input int n);
    return (n >= 1) && (n <= 7) && ((n % 2) == 1);
  endfunction

  // Number of ones that still loses the vote: more than this means the bit is 1.
  function automatic int majority_thresh(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_majority_sampler_if.sv
// Bundle between the RX edge/bit counter (master) and the majority sampler (slave).
//   Prescale      : clocks per bit
//   RX_IN         : raw serial line
//   data_samp_en  : sampling enable from the RX FSM
//   edge_cnt      : clock index within the current bit
//   sampled_bit   : voted bit value
//   sample_valid  : one-cycle strobe when sampled_bit updates
//   noise_err     : last vote was not unanimous
interface uart_rx_majority_sampler_if
  import uart_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF
);

  logic [PRESC_W-1:0] Prescale;
  logic               RX_IN;
  logic               data_samp_en;
  logic [PRESC_W-1:0] edge_cnt;
  logic               sampled_bit;
  logic               sample_valid;
  logic               noise_err;

  modport master (
    output Prescale, RX_IN, data_samp_en, edge_cnt,
    input  sampled_bit, sample_valid, noise_err
  );

  modport slave (
    input  Prescale, RX_IN, data_samp_en, edge_cnt,
    output sampled_bit, sample_valid, noise_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Reset-to-1 synchronizer for the serial line; shared with the start-bit detector.
//   CLK, RST : clock and asynchronous active-low reset
//   i_d      : asynchronous input
//   o_q      : i_d delayed by STAGES clocks (STAGES = 0 passes i_d straight through)
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < 0 || STAGES > 3) begin : g_bad_stages
    $error("uart_rx_sync: STAGES must be in 0..3");
  end

  if (STAGES == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_flops
    // Flops reset to 1 so the line looks idle until real data has propagated.
    logic [STAGES-1:0] r_ff;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_ff <= '1;
      end else begin
        r_ff[0] <= i_d;
        for (int i = 1; i < STAGES; i++) begin
          r_ff[i] <= r_ff[i-1];
        end
      end
    end

    assign o_q = r_ff[STAGES-1];
  end

endmodule

// File: rtl/uart_rx_majority_sampler.sv
// UART receive-bit sampler: takes NUM_SAMPLES readings of the synchronized line
// centred on the bit midpoint and decides the bit by majority vote.
//   CLK, RST : oversample clock, asynchronous active-low reset
//   bus      : slave side of uart_rx_majority_sampler_if (see interface header)
module uart_rx_majority_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W     = PRESC_W_DEF,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  uart_rx_majority_sampler_if.slave        bus
);

  if (!num_samples_ok(NUM_SAMPLES)) begin : g_bad_num_samples
    $error("uart_rx_majority_sampler: NUM_SAMPLES must be odd in 1..7");
  end

  localparam int K     = majority_thresh(NUM_SAMPLES);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int W     = PRESC_W + 1;

  logic             w_rx_s;
  logic [W-1:0]     w_half;
  logic [W-1:0]     w_first;
  logic [W-1:0]     w_last;
  logic [W-1:0]     w_edge;
  logic             w_at_first;
  logic             w_in_win;
  logic             w_at_last;
  logic [CNT_W-1:0] w_ones_next;

  logic [CNT_W-1:0] r_ones;
  logic             r_bit;
  logic             r_valid;
  logic             r_noise;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .i_d (bus.RX_IN),
    .o_q (w_rx_s)
  );

  // One extra bit of headroom so first+NUM_SAMPLES-1 cannot wrap; a window that
  // runs past Prescale-1 is simply never reached by edge_cnt, so no vote happens.
  assign w_half     = {1'b0, bus.Prescale} >> 1;
  assign w_first    = (w_half >= W'(K)) ? (w_half - W'(K)) : '0;
  assign w_last     = w_first + W'(NUM_SAMPLES - 1);
  assign w_edge     = {1'b0, bus.edge_cnt};
  assign w_at_first = bus.data_samp_en && (w_edge == w_first);
  assign w_in_win   = bus.data_samp_en && (w_edge > w_first) && (w_edge <= w_last);
  assign w_at_last  = bus.data_samp_en && (w_edge == w_last);

  // The first slot loads rather than adds, discarding anything an aborted bit left behind.
  always_comb begin
    w_ones_next = r_ones;
    if (!bus.data_samp_en) begin
      w_ones_next = '0;
    end else if (w_at_first) begin
      w_ones_next = CNT_W'(w_rx_s);
    end else if (w_in_win) begin
      w_ones_next = r_ones + CNT_W'(w_rx_s);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ones  <= '0;
      r_bit   <= 1'b1;
      r_valid <= 1'b0;
      r_noise <= 1'b0;
    end else begin
      r_ones  <= w_ones_next;
      r_valid <= w_at_last;
      if (w_at_last) begin
        r_bit   <= (w_ones_next > CNT_W'(K));
        r_noise <= (w_ones_next != '0) && (w_ones_next != CNT_W'(NUM_SAMPLES));
      end
    end
  end

  assign bus.sampled_bit  = r_bit;
  assign bus.sample_valid = r_valid;
  assign bus.noise_err    = r_noise;

endmodule
